divider: RTL and testbench

//  Multi-cycle radix-2 restoring integer divider for DIV/DIVU, used in the EX stage.

---
 rtl/divider_pkg.sv | 8 +
 rtl/divider.sv | 120 ++++++++++++
 tb/tb_divider.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared divider definitions: FSM state encoding and default operand width.
package divider_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// LO = quotient, HI = remainder; the result is held until the E stage advances.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic             div_ready,
  output logic             div_busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_ready;
  logic             r_busy;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  assign w_a_neg = div_signed & dividend[WIDTH-1];
  assign w_b_neg = div_signed & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  // Trial subtract is one bit wider so the shifted-out remainder bit is kept.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_dvsr};
  assign w_rem_nx = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else if (flush_e) begin
      r_state <= DIV_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (div_en) begin
            r_quo   <= w_a_mag;
            r_dvsr  <= w_b_mag;
            r_rem   <= '0;
            // Divide-by-zero keeps the all-ones quotient unsigned-looking.
            r_qneg  <= (w_a_neg ^ w_b_neg) && (divisor != '0);
            r_rneg  <= w_a_neg;
            r_cnt   <= CW'(WIDTH);
            r_state <= DIV_BUSY;
            r_busy  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_q_out <= r_qneg ? (~w_quo_nx + 1'b1) : w_quo_nx;
            r_r_out <= r_rneg ? (~w_rem_nx + 1'b1) : w_rem_nx;
            r_state <= DIV_DONE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        DIV_DONE: begin
          if (!stall_e) begin
            r_state <= DIV_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= DIV_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign div_ready = r_ready;
  assign div_busy  = r_busy;
  assign quotient  = r_q_out;
  assign remainder = r_r_out;

endmodule

// File: tb/tb_divider.sv
// Directed vector bench for the multi-cycle divider: latency, sign rules,
// stall hold, flush and asynchronous reset.
module tb_divider;

  logic        clk;
  logic        resetn;
  logic        div_en;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_e;
  logic        flush_e;
  logic        div_ready;
  logic        div_busy;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int errors = 0;
  int checks = 0;

  divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_en    (div_en),
    .div_signed(div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .stall_e   (stall_e),
    .flush_e   (flush_e),
    .div_ready (div_ready),
    .div_busy  (div_busy),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the E stage advanced.
  // div_en is left high so the caller can chain the next divide back-to-back.
  task automatic do_div(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] qe,
                        input logic [31:0] re, input int hold);
    int lat;
    logic [31:0] q0, r0;
    div_en     = 1'b1;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    stall_e    = 1'b1;
    flush_e    = 1'b0;
    @(posedge clk);
    #1;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 0;
    while (!div_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd33);
    chk({nm, "_q"}, quotient, qe);
    chk({nm, "_r"}, remainder, re);
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_ready"}, 32'(div_ready), 32'd1);
      chk({nm, "_hold_busy"}, 32'(div_busy), 32'd0);
      chk({nm, "_hold_q"}, quotient, q0);
      chk({nm, "_hold_r"}, remainder, r0);
    end
    stall_e = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_fall"}, 32'(div_ready), 32'd0);
  endtask

  vec_t vecs[12];
  int   seen;

  initial begin
    vecs[0]  = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{"div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4]  = '{"divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{"div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[6]  = '{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[7]  = '{"divu_max_10",  1'b0, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5};
    vecs[8]  = '{"div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[9]  = '{"divu_min_max", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[10] = '{"div_3_7",      1'b1, 32'd3,          32'd7,          32'd0,          32'd3};
    vecs[11] = '{"divu_dead_16", 1'b0, 32'hDEAD_BEEF,  32'd16,         32'h0DEA_DBEE,  32'hF};

    resetn     = 1'b0;
    div_en     = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    stall_e    = 1'b0;
    flush_e    = 1'b0;
    #1;
    chk("reset_ready", 32'(div_ready), 32'd0);
    chk("reset_busy", 32'(div_busy), 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0);
      div_en = 1'b0;
      @(negedge clk);
    end

    // Result held under stall, then an immediate back-to-back DIVU.
    do_div("hold_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 4);
    do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
    div_en = 1'b0;
    @(negedge clk);
    chk("b2b_idle_busy", 32'(div_busy), 32'd0);

    // Flush in the middle of BUSY.
    div_en     = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd50;
    divisor    = 32'd3;
    stall_e    = 1'b1;
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", 32'(div_busy), 32'd1);
    flush_e = 1'b1;
    @(negedge clk);
    flush_e = 1'b0;
    div_en  = 1'b0;
    chk("flush_busy", 32'(div_busy), 32'd0);
    chk("flush_ready", 32'(div_ready), 32'd0);
    chk("flush_q_kept", quotient, 32'd3);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_ready) seen = 1;
    end
    chk("flush_no_ready", 32'(seen), 32'd0);

    // Flush coinciding with the start cycle must not start.
    div_en  = 1'b1;
    flush_e = 1'b1;
    @(negedge clk);
    flush_e = 1'b0;
    chk("flush_start_busy", 32'(div_busy), 32'd0);
    do_div("after_flush_8_2", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 0);
    div_en = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of BUSY.
    div_en     = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd77;
    divisor    = 32'd5;
    repeat (15) @(negedge clk);
    chk("rst_pre_busy", 32'(div_busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_ready", 32'(div_ready), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    div_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_div("after_rst_77_5", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 0);
    div_en = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
